synapse_scheduler: RTL

Sequencer and arbiter for the per-neuron synaptic weight RAM. Shares the single RAM port between a configuration writer (host/loader) and up to N_NEURONS spike requesters. It serialises weight writes and AER-addressed weight reads, and returns each fetched weight with a valid strobe to the downstream integrate stage. It also issues the RAM's synchronous clear after every reset.

---
 rtl/synapse_scheduler_pkg.sv | 15 +
 rtl/synapse_scheduler_rr_arbiter.sv | 31 +++
 rtl/synapse_scheduler.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/synapse_scheduler_pkg.sv
// Shared definitions for the synaptic weight RAM scheduler.
package synapse_scheduler_pkg;

   localparam int DEF_AW = 4;
   localparam int DEF_WW = 11;

   typedef enum logic [2:0] {
      S_INIT  = 3'd0,
      S_IDLE  = 3'd1,
      S_WRITE = 3'd2,
      S_READ  = 3'd3,
      S_RESP  = 3'd4
   } state_t;

endpackage

// File: rtl/synapse_scheduler_rr_arbiter.sv
// Round-robin next-grant search over the spike requesters, starting one past ptr.
module rr_arbiter #(
   parameter int N_NEURONS = 4,
   parameter int AW        = 4
) (
   input  logic [N_NEURONS-1:0] req,
   input  logic [AW-1:0]        ptr,
   output logic [N_NEURONS-1:0] grant,
   output logic [AW-1:0]        idx,
   output logic                 any_req
);

   // Walk from the farthest slot towards ptr+1 so the nearest set bit is the last to overwrite.
   always_comb begin
      int k;
      grant   = '0;
      idx     = '0;
      any_req = 1'b0;
      k       = 0;
      for (int i = N_NEURONS; i >= 1; i--) begin
         k = (int'(ptr) + i) % N_NEURONS;
         if (req[k]) begin
            grant    = '0;
            grant[k] = 1'b1;
            idx      = AW'(k);
            any_req  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/synapse_scheduler.sv
// Shares the single weight-RAM port between a config writer and the spike requesters.
//
//  state   | meaning
//  --------+--------------------------------------------------------------
//  S_INIT  | ram_rst high for one cycle to clear every RAM word
//  S_IDLE  | arbitrate cfg vs spikes, launch one transaction
//  S_WRITE | ram_we drops, cfg_ready (and cfg_err if dropped) pulse
//  S_READ  | ram_aer_bus held, RAM latches the addressed word
//  S_RESP  | return weight with w_valid and one-hot spike_ack
module synapse_scheduler
   import synapse_scheduler_pkg::*;
#(
   parameter int N_NEURONS = 4,
   parameter int AW        = DEF_AW,
   parameter int WW        = DEF_WW
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_NEURONS-1:0] spike_req,
   output logic [N_NEURONS-1:0] spike_ack,
   input  logic                 cfg_valid,
   input  logic [AW-1:0]        cfg_addr,
   input  logic [WW-1:0]        cfg_weight,
   output logic                 cfg_ready,
   output logic                 cfg_err,
   output logic                 ram_rst,
   output logic                 ram_we,
   output logic [AW-1:0]        ram_syn_addr,
   output logic [WW-1:0]        ram_syn_weight,
   output logic [AW-1:0]        ram_aer_bus,
   input  logic [WW-1:0]        ram_weight_out,
   output logic                 w_valid,
   output logic [AW-1:0]        w_addr,
   output logic [WW-1:0]        w_data
);

   localparam logic [AW-1:0] PTR_RST = AW'(N_NEURONS - 1);

   state_t               state;
   logic [AW-1:0]        ptr;
   logic                 last_cfg;
   logic                 err_pend;
   logic [N_NEURONS-1:0] ack_oh;

   logic [N_NEURONS-1:0] req_eff;
   logic [N_NEURONS-1:0] gnt_oh;
   logic [AW-1:0]        gnt_idx;
   logic                 any_req;
   logic                 cfg_eff;
   logic                 cfg_ok;
   logic                 take_cfg;

   // A requester still holds its line during its ack/ready cycle; mask it so IDLE cannot re-grant it.
   assign req_eff  = spike_req & ~spike_ack;
   assign cfg_eff  = cfg_valid & ~cfg_ready;
   assign cfg_ok   = int'(cfg_addr) < N_NEURONS;
   assign take_cfg = cfg_eff && !(last_cfg && any_req);

   rr_arbiter #(
      .N_NEURONS (N_NEURONS),
      .AW        (AW)
   ) u_arb (
      .req     (req_eff),
      .ptr     (ptr),
      .grant   (gnt_oh),
      .idx     (gnt_idx),
      .any_req (any_req)
   );

   // Sequencer: one transaction in flight, all outputs registered.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= S_INIT;
         ptr            <= PTR_RST;
         last_cfg       <= 1'b0;
         err_pend       <= 1'b0;
         ack_oh         <= '0;
         ram_rst        <= 1'b1;
         ram_we         <= 1'b0;
         ram_syn_addr   <= '0;
         ram_syn_weight <= '0;
         ram_aer_bus    <= '0;
         spike_ack      <= '0;
         cfg_ready      <= 1'b0;
         cfg_err        <= 1'b0;
         w_valid        <= 1'b0;
         w_addr         <= '0;
         w_data         <= '0;
      end else begin
         ram_rst   <= 1'b0;
         ram_we    <= 1'b0;
         spike_ack <= '0;
         cfg_ready <= 1'b0;
         cfg_err   <= 1'b0;
         w_valid   <= 1'b0;
         case (state)
            S_INIT: begin
               state <= S_IDLE;
            end
            S_IDLE: begin
               if (take_cfg) begin
                  last_cfg <= 1'b1;
                  err_pend <= !cfg_ok;
                  if (cfg_ok) begin
                     ram_we         <= 1'b1;
                     ram_syn_addr   <= cfg_addr;
                     ram_syn_weight <= cfg_weight;
                  end
                  state <= S_WRITE;
               end else if (any_req) begin
                  last_cfg    <= 1'b0;
                  ptr         <= gnt_idx;
                  ram_aer_bus <= gnt_idx;
                  ack_oh      <= gnt_oh;
                  state       <= S_READ;
               end
            end
            S_WRITE: begin
               cfg_ready <= 1'b1;
               cfg_err   <= err_pend;
               state     <= S_IDLE;
            end
            S_READ: begin
               state <= S_RESP;
            end
            S_RESP: begin
               w_data    <= ram_weight_out;
               w_addr    <= ram_aer_bus;
               w_valid   <= 1'b1;
               spike_ack <= ack_oh;
               state     <= S_IDLE;
            end
            default: begin
               state <= S_INIT;
            end
         endcase
      end
   end

endmodule
